// File: rtl/pipe_pkg.sv
// Shared state encoding and default widths for the pipeline skid register.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 160;
  localparam int unsigned DEF_CTRL_W = 24;
  localparam int unsigned DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a 0..2 increment; used to count flushed entries.
module sat_counter #(
  parameter int unsigned CNT_W = pipe_pkg::DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W:0] MAX_VAL = {1'b0, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W:0]   w_sum;

  // One extra bit of headroom so the overflow is visible before clamping.
  assign w_sum = (CNT_W+1)'(r_cnt) + (CNT_W+1)'(i_inc);
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_sum > MAX_VAL) begin
      r_cnt <= MAX_VAL[CNT_W-1:0];
    end else begin
      r_cnt <= w_sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid register stage: in_ready depends only on flops and en, never
// on out_ready, so the stage breaks the backpressure timing path.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned CTRL_W     = DEF_CTRL_W,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  discard_cnt
);

  state_t            r_state;
  logic              r_main_vld;
  logic              r_skid_vld;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [DATA_W-1:0] r_skid_data;

  logic       w_accept;
  logic       w_emit;
  logic [1:0] w_inc;

  // Reset gating keeps both handshakes low while the block is held in reset.
  assign in_ready  = en & reset & (r_state != FULL);
  assign out_valid = en & r_main_vld;
  assign w_accept  = in_valid & in_ready;
  assign w_emit    = out_valid & out_ready;

  assign out_ctrl  = out_valid ? r_main_ctrl : '0;
  assign out_data  = (out_valid || !CLEAR_DATA) ? r_main_data : '0;
  assign occupancy = 2'(r_main_vld) + 2'(r_skid_vld);

  // A payload emitted in the flush cycle reached downstream, so it is not lost.
  assign w_inc = flush ? (occupancy - 2'(w_emit)) : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= EMPTY;
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      r_main_data <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_main_vld  <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
      if (CLEAR_DATA) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end
    end else if (en) begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main_vld  <= 1'b1;
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
            r_state     <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept && w_emit) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
          end else if (w_accept) begin
            r_skid_vld  <= 1'b1;
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
            r_state     <= FULL;
          end else if (w_emit) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= '0;
            if (CLEAR_DATA) r_main_data <= '0;
            r_state     <= EMPTY;
          end
        end
        FULL: begin
          if (w_emit) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
            if (CLEAR_DATA) r_skid_data <= '0;
            r_state     <= BUSY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_discard_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_inc),
    .o_cnt (discard_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a FIFO-of-payloads model checked every
// cycle, plus a narrow-counter instance to observe discard saturation.
module tb_pipe_skid_reg;

  localparam int unsigned DW = 160;
  localparam int unsigned CW = 24;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  localparam beat_t ZB = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [7:0]    discard_cnt;

  logic          in_ready2, out_valid2;
  logic [CW-1:0] out_ctrl2;
  logic [DW-1:0] out_data2;
  logic [1:0]    occupancy2;
  logic [1:0]    discard_cnt2;

  beat_t sb[$];
  int    raw_disc = 0;
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .discard_cnt(discard_cnt)
  );

  pipe_skid_reg #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready2), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_ctrl(out_ctrl2), .out_data(out_data2),
    .occupancy(occupancy2), .discard_cnt(discard_cnt2)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    b.c = CW'($urandom);
    b.d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return b;
  endfunction

  // Monitor: compare outputs against the model, then retire emitted/flushed entries.
  always @(negedge clk) begin : mon
    int    sz;
    bit    e_rdy, e_vld, emit;
    beat_t h;
    sz    = sb.size();
    h     = (sz > 0) ? sb[0] : ZB;
    e_rdy = en && reset && (sz < 2);
    e_vld = en && reset && (sz > 0);
    chk("in_ready",  DW'(in_ready),  DW'(e_rdy));
    chk("out_valid", DW'(out_valid), DW'(e_vld));
    chk("out_ctrl",  DW'(out_ctrl),  e_vld ? DW'(h.c) : '0);
    chk("out_data",  out_data,       e_vld ? h.d : '0);
    chk("occupancy", DW'(occupancy), DW'(sz));
    chk("discard_cnt",  DW'(discard_cnt),  DW'((raw_disc > 255) ? 255 : raw_disc));
    chk("discard_cnt2", DW'(discard_cnt2), DW'((raw_disc > 3) ? 3 : raw_disc));
    chk("occupancy2",   DW'(occupancy2),   DW'(sz));
    chk("out_valid2",   DW'(out_valid2),   DW'(e_vld));
    emit = e_vld && out_ready;
    if (reset) begin
      if (flush) begin
        raw_disc = raw_disc + sz - int'(emit);
        sb.delete();
      end else if (emit) begin
        void'(sb.pop_front());
      end
    end
  end

  // Drive one cycle starting at posedge+1; record the accepted payload at the edge.
  task automatic cyc(input bit e, input bit f, input bit iv, input beat_t b, input bit ordy);
    bit acc;
    en = e; flush = f; in_valid = iv; in_ctrl = b.c; in_data = b.d; out_ready = ordy;
    acc = iv && e && reset && (sb.size() < 2) && !f;
    @(posedge clk);
    if (acc) sb.push_back(b);
    #1;
  endtask

  task automatic fill_full();
    cyc(1, 0, 1, rnd_beat(), 0);
    cyc(1, 0, 1, rnd_beat(), 0);
  endtask

  initial begin
    beat_t kb;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    en    = 1'b1;

    // Stream: one beat per cycle, ctrl = data = k.
    for (int k = 0; k < 10; k++) begin
      kb.c = CW'(k);
      kb.d = DW'(k);
      cyc(1, 0, 1, kb, 1);
    end
    cyc(1, 0, 0, ZB, 1);

    // Backpressure: A then B held, then drained in order.
    fill_full();
    cyc(1, 0, 0, ZB, 0);
    cyc(1, 0, 0, ZB, 1);
    cyc(1, 0, 0, ZB, 1);
    cyc(1, 0, 0, ZB, 1);

    // Flush while full with a valid input, then repeated full flushes to saturate.
    repeat (3) begin
      fill_full();
      cyc(1, 1, 1, rnd_beat(), 0);
      cyc(1, 0, 0, ZB, 0);
    end

    // Flush coinciding with an emit counts only the remaining entry.
    fill_full();
    cyc(1, 1, 0, ZB, 1);
    cyc(1, 0, 0, ZB, 1);

    // Freeze: BUSY holding A, en low with out_ready high, then resume.
    cyc(1, 0, 1, rnd_beat(), 0);
    repeat (3) cyc(0, 0, 0, ZB, 1);
    cyc(1, 0, 0, ZB, 1);
    cyc(1, 0, 0, ZB, 1);

    // Asynchronous reset mid-cycle while full.
    fill_full();
    #2;
    reset = 1'b0;
    sb.delete();
    raw_disc = 0;
    #1;
    chk("rst_out_valid", DW'(out_valid), '0);
    chk("rst_in_ready",  DW'(in_ready),  '0);
    chk("rst_out_ctrl",  DW'(out_ctrl),  '0);
    chk("rst_out_data",  out_data,       '0);
    chk("rst_occupancy", DW'(occupancy), '0);
    chk("rst_discard",   DW'(discard_cnt), '0);
    @(posedge clk);
    #1;
    cyc(1, 0, 1, rnd_beat(), 1);
    cyc(1, 0, 1, rnd_beat(), 1);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", DW'(in_ready), 1);
    cyc(1, 0, 1, rnd_beat(), 1);
    cyc(1, 0, 0, ZB, 1);

    // Randomized traffic.
    repeat (1500) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < 7, rnd_beat(), $urandom_range(0, 9) < 6);
    end
    repeat (4) cyc(1, 0, 0, ZB, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
